// File: rtl/cache_controller.sv
// Two-way set-associative write-through, no-write-allocate data cache in front of SramController.
// Optional read hit/miss statistics counters are enabled by defining CACHE_STATS_EN.
module cache_controller #(
  parameter int SET_BITS = 6,
  parameter int TAG_BITS = 17 - SET_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_writeData,
  input  logic [31:0] sram_readData,
  input  logic        sram_ready,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int SETS = 1 << SET_BITS;

  typedef enum logic [1:0] {IDLE, READ_MISS, WRITE} state_t;

  state_t state_q, state_d;

  logic                valid0_q [SETS];
  logic                valid1_q [SETS];
  logic                lru_q    [SETS];
  logic [TAG_BITS-1:0] tag0_q   [SETS];
  logic [TAG_BITS-1:0] tag1_q   [SETS];
  logic [31:0]         data0_q  [SETS];
  logic [31:0]         data1_q  [SETS];

  logic [SET_BITS-1:0] idx;
  logic [TAG_BITS-1:0] tag;
  logic hit0, hit1, hit;
  logic rd_hit, rd_miss, fill, wr_upd, victim1;

  assign idx  = address[SET_BITS+1:2];
  assign tag  = address[SET_BITS+2+TAG_BITS-1:SET_BITS+2];
  assign hit0 = valid0_q[idx] && (tag0_q[idx] == tag);
  assign hit1 = valid1_q[idx] && (tag1_q[idx] == tag);
  assign hit  = hit0 || hit1;

  assign rd_hit  = (state_q == IDLE) && rd_en && !wr_en && hit;
  assign rd_miss = (state_q == IDLE) && rd_en && !wr_en && !hit;
  assign fill    = (state_q == READ_MISS) && sram_ready;
  assign wr_upd  = (state_q == WRITE) && sram_ready && hit;
  // Fill goes to the first invalid way; with both valid the LRU bit names the victim.
  assign victim1 = valid0_q[idx] && (!valid1_q[idx] || lru_q[idx]);

  assign sram_address   = address;
  assign sram_writeData = writeData;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (wr_en)        state_d = WRITE;
        else if (rd_miss) state_d = READ_MISS;
      end
      READ_MISS: if (sram_ready) state_d = IDLE;
      WRITE:     if (sram_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    ready      = 1'b1;
    readData   = '0;
    sram_rd_en = 1'b0;
    sram_wr_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_en) begin
          ready = 1'b0;
        end else if (rd_en) begin
          ready = hit;
          if (hit) readData = hit0 ? data0_q[idx] : data1_q[idx];
        end
      end
      READ_MISS: begin
        sram_rd_en = 1'b1;
        ready      = sram_ready;
        if (sram_ready) readData = sram_readData;
      end
      WRITE: begin
        sram_wr_en = 1'b1;
        ready      = sram_ready;
      end
      default: ready = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < SETS; i++) begin
        valid0_q[i] <= 1'b0;
        valid1_q[i] <= 1'b0;
        lru_q[i]    <= 1'b0;
      end
    end else if (fill) begin
      if (victim1) valid1_q[idx] <= 1'b1;
      else         valid0_q[idx] <= 1'b1;
      lru_q[idx] <= !victim1;
    end else if (rd_hit || wr_upd) begin
      lru_q[idx] <= hit0;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      if (victim1) begin
        tag1_q[idx]  <= tag;
        data1_q[idx] <= sram_readData;
      end else begin
        tag0_q[idx]  <= tag;
        data0_q[idx] <= sram_readData;
      end
    end else if (wr_upd) begin
      if (hit0) data0_q[idx] <= writeData;
      else      data1_q[idx] <= writeData;
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (rd_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (rd_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: miss/fill, hit, LRU eviction, write-through, no-allocate, reset abort.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, writeData, readData;
  logic        ready, sram_rd_en, sram_wr_en;
  logic [31:0] sram_address, sram_writeData, sram_readData;
  logic        sram_ready;
  logic [31:0] hit_count, miss_count;

  int checks = 0;
  int errors = 0;

`ifdef CACHE_STATS_EN
  localparam logic [31:0] EXP_HITS1 = 32'd1;
  localparam logic [31:0] EXP_MISS1 = 32'd1;
`else
  localparam logic [31:0] EXP_HITS1 = 32'd0;
  localparam logic [31:0] EXP_MISS1 = 32'd0;
`endif

  cache_controller dut (
    .clk            (clk),
    .rst            (rst),
    .rd_en          (rd_en),
    .wr_en          (wr_en),
    .address        (address),
    .writeData      (writeData),
    .readData       (readData),
    .ready          (ready),
    .sram_rd_en     (sram_rd_en),
    .sram_wr_en     (sram_wr_en),
    .sram_address   (sram_address),
    .sram_writeData (sram_writeData),
    .sram_readData  (sram_readData),
    .sram_ready     (sram_ready),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tg, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; address must miss. Returns at a negedge back in IDLE.
  task automatic read_miss(input logic [31:0] a, input logic [31:0] d, input string tg);
    rd_en = 1'b1; wr_en = 1'b0; address = a;
    #1 chk({tg, "_req_ready"}, {31'd0, ready}, 32'd0);
    chk({tg, "_req_srd"}, {31'd0, sram_rd_en}, 32'd0);
    @(negedge clk);
    chk({tg, "_wait_srd"}, {31'd0, sram_rd_en}, 32'd1);
    chk({tg, "_wait_ready"}, {31'd0, ready}, 32'd0);
    chk({tg, "_sram_addr"}, sram_address, a);
    @(negedge clk);
    chk({tg, "_held_srd"}, {31'd0, sram_rd_en}, 32'd1);
    sram_ready = 1'b1; sram_readData = d;
    #1 chk({tg, "_done_ready"}, {31'd0, ready}, 32'd1);
    chk({tg, "_done_data"}, readData, d);
    @(negedge clk);
    sram_ready = 1'b0; rd_en = 1'b0; sram_readData = '0;
  endtask

  task automatic read_hit(input logic [31:0] a, input logic [31:0] exp, input string tg);
    rd_en = 1'b1; wr_en = 1'b0; address = a;
    #1 chk({tg, "_ready"}, {31'd0, ready}, 32'd1);
    chk({tg, "_data"}, readData, exp);
    chk({tg, "_srd"}, {31'd0, sram_rd_en}, 32'd0);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic write_op(input logic [31:0] a, input logic [31:0] d, input logic rd_too, input string tg);
    wr_en = 1'b1; rd_en = rd_too; address = a; writeData = d;
    #1 chk({tg, "_req_ready"}, {31'd0, ready}, 32'd0);
    @(negedge clk);
    chk({tg, "_swr"}, {31'd0, sram_wr_en}, 32'd1);
    chk({tg, "_srd"}, {31'd0, sram_rd_en}, 32'd0);
    chk({tg, "_sdata"}, sram_writeData, d);
    chk({tg, "_wait_ready"}, {31'd0, ready}, 32'd0);
    @(negedge clk);
    chk({tg, "_held_swr"}, {31'd0, sram_wr_en}, 32'd1);
    sram_ready = 1'b1;
    #1 chk({tg, "_done_ready"}, {31'd0, ready}, 32'd1);
    @(negedge clk);
    sram_ready = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    #1 chk({tg, "_idle_swr"}, {31'd0, sram_wr_en}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = '0; writeData = '0;
    sram_readData = '0; sram_ready = 1'b0;
    #12;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_rdata", readData, 32'd0);
    chk("rst_srd", {31'd0, sram_rd_en}, 32'd0);
    chk("rst_swr", {31'd0, sram_wr_en}, 32'd0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_miss", miss_count, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // First fill of set 0 way0, then same-cycle hit
    read_miss(32'h0000_0100, 32'hDEAD_BEEF, "m100");
    read_hit(32'h0000_0100, 32'hDEAD_BEEF, "h100");
    #1 chk("stat_hits", hit_count, EXP_HITS1);
    chk("stat_miss", miss_count, EXP_MISS1);
    chk("idle_rdata", readData, 32'd0);
    @(negedge clk);

    // Set 0 fills way1, then third tag evicts LRU way0 (0x100)
    read_miss(32'h0000_0300, 32'h3333_3333, "m300");
    read_miss(32'h0000_0500, 32'h5555_5555, "m500");
    read_hit(32'h0000_0500, 32'h5555_5555, "h500");
    read_hit(32'h0000_0300, 32'h3333_3333, "h300");
    read_miss(32'h0000_0100, 32'h1111_1111, "m100b");

    // Write-through hit updates cached data
    write_op(32'h0000_0300, 32'h1234_5678, 1'b0, "w300");
    @(negedge clk);
    read_hit(32'h0000_0300, 32'h1234_5678, "h300w");

    // Write miss does not allocate
    write_op(32'h0000_0700, 32'hCAFE_F00D, 1'b0, "w700");
    @(negedge clk);
    read_miss(32'h0000_0700, 32'h7777_7777, "m700");
    read_hit(32'h0000_0700, 32'h7777_7777, "h700");
    read_hit(32'h0000_0300, 32'h1234_5678, "h300k");

    // Simultaneous read and write takes the write path
    write_op(32'h0000_0700, 32'hAAAA_5555, 1'b1, "rw700");
    @(negedge clk);
    read_hit(32'h0000_0700, 32'hAAAA_5555, "h700w");

    // Reset mid-miss abandons the access and invalidates the cache
    rd_en = 1'b1; address = 32'h0000_0900;
    @(negedge clk);
    chk("rm_srd_before", {31'd0, sram_rd_en}, 32'd1);
    rst = 1'b0;
    #1 chk("rm_srd_after", {31'd0, sram_rd_en}, 32'd0);
    chk("rm_hits", hit_count, 32'd0);
    chk("rm_miss", miss_count, 32'd0);
    rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    read_miss(32'h0000_0900, 32'h9999_9999, "m900");
    read_miss(32'h0000_0700, 32'h7070_7070, "m700r");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
